// File: rtl/piso_stream_if.sv
// Stream/FIFO bundle for piso_stream: FIFO read side plus valid/ready serial side.
// master = the converter, slave = the FIFO/sink environment.
interface piso_stream_if #(
  parameter int IN_WIDTH  = 1024,
  parameter int OUT_WIDTH = 64
);
  logic                 fifo_empty;
  logic                 fifo_re;
  logic [IN_WIDTH-1:0]  i_parallel;
  logic [OUT_WIDTH-1:0] o_serial;
  logic                 o_valid;
  logic                 o_ready;
  logic                 o_first;
  logic                 o_last;

  modport master (
    input  fifo_empty, i_parallel, o_ready,
    output fifo_re, o_serial, o_valid, o_first, o_last
  );

  modport slave (
    output fifo_empty, i_parallel, o_ready,
    input  fifo_re, o_serial, o_valid, o_first, o_last
  );
endinterface

// File: rtl/piso_stream.sv
// Wide FIFO word -> N narrow slices with backpressure and one-word prefetch.
// Define PISO_STREAM_FRAMING_EN to get registered o_first/o_last markers.
module piso_stream #(
  parameter int IN_WIDTH  = 1024,
  parameter int OUT_WIDTH = 64,
  parameter bit MSB_FIRST = 1'b0
) (
  input logic         clk,
  input logic         rst_n,
  input logic         ce,
  piso_stream_if.master bus
);
  localparam int N  = IN_WIDTH / OUT_WIDTH;
  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  logic [IN_WIDTH-1:0]  cur, nxt, cur_d, nxt_d;
  logic                 cur_vld, nxt_vld, cur_vld_d, nxt_vld_d;
  logic                 rd_pend, fifo_re, re_d;
  logic [IW-1:0]        idx, idx_d, sel;
  logic                 xfer, last, vacate;
  logic [1:0]           fill_d;
  logic [N-1:0][OUT_WIDTH-1:0] slices;
  logic [OUT_WIDTH-1:0] serial_q;

  assign xfer   = cur_vld & bus.o_ready;
  assign last   = (idx == LAST);
  // cur empties this cycle with nothing queued behind it: landing data refills it directly
  assign vacate = xfer & last & ~nxt_vld;

  always_comb begin
    cur_d     = cur;
    nxt_d     = nxt;
    cur_vld_d = cur_vld;
    nxt_vld_d = nxt_vld;
    idx_d     = idx;
    if (xfer) begin
      if (last) begin
        idx_d = '0;
        if (nxt_vld) begin
          cur_d     = nxt;
          nxt_vld_d = 1'b0;
        end else if (rd_pend) begin
          cur_d = bus.i_parallel;
        end else begin
          cur_vld_d = 1'b0;
        end
      end else begin
        idx_d = idx + IW'(1);
      end
    end
    if (rd_pend && !vacate) begin
      if (!cur_vld) begin
        cur_d     = bus.i_parallel;
        cur_vld_d = 1'b1;
        idx_d     = '0;
      end else begin
        nxt_d     = bus.i_parallel;
        nxt_vld_d = 1'b1;
      end
    end
  end

  // fifo_re itself counts as in flight next cycle (it becomes rd_pend). Back-to-back
  // reads are also blocked: fifo_empty does not yet reflect the pop of a read issued now.
  assign fill_d = 2'(cur_vld_d) + 2'(nxt_vld_d) + 2'(fifo_re);
  assign re_d   = ~bus.fifo_empty & ~fifo_re & (fill_d < 2'd2);

  assign slices = cur_d;
  assign sel    = MSB_FIRST ? (LAST - idx_d) : idx_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur      <= '0;
      nxt      <= '0;
      cur_vld  <= 1'b0;
      nxt_vld  <= 1'b0;
      idx      <= '0;
      rd_pend  <= 1'b0;
      fifo_re  <= 1'b0;
      serial_q <= '0;
    end else if (ce) begin
      cur      <= cur_d;
      nxt      <= nxt_d;
      cur_vld  <= cur_vld_d;
      nxt_vld  <= nxt_vld_d;
      idx      <= idx_d;
      rd_pend  <= fifo_re;
      fifo_re  <= re_d;
      serial_q <= slices[sel];
    end
  end

  assign bus.fifo_re  = fifo_re;
  assign bus.o_serial = serial_q;
  assign bus.o_valid  = cur_vld;

`ifdef PISO_STREAM_FRAMING_EN
  logic first_q, last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else if (ce) begin
      first_q <= cur_vld_d & (idx_d == '0);
      last_q  <= cur_vld_d & (idx_d == LAST);
    end
  end

  assign bus.o_first = first_q;
  assign bus.o_last  = last_q;
`else
  assign bus.o_first = 1'b0;
  assign bus.o_last  = 1'b0;
`endif
endmodule
